mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one memory bus between the instruction-read requester (imr) and the load/store requester (dmr).
//  Each requester issues a 1-cycle req pulse with addr/ctrl; the arbiter latches it, grants round-robin,
//  issues a 1-cycle m_req, waits for m_valid and routes valid/data back to the owner. Sits between the
//  CPU fetch/LSU stages and the memory/peripheral bus. Timeout watchdog returns ERR_DATA on a hung bus.
// PARAMETERS
//  TIMEOUT   256           cycles in WAIT before forced completion (>=2)
//  TO_W      9             timeout counter width, must hold TIMEOUT
//  ERR_DATA  32'h0000_0013 read data returned on timeout (NOP)
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  i_read_req    in   1   imr request pulse (1 cycle)
//  i_read_w      in   1   imr word access
//  i_read_hw     in   1   imr half-word access
//  i_read_adr    in   32  imr byte address
//  i_read_valid  out  1   imr completion pulse
//  i_read_data   out  32  imr read data, valid with i_read_valid
//  d_req         in   1   dmr request pulse (1 cycle)
//  d_we          in   1   dmr write (1) / read (0)
//  d_w           in   1   dmr word access
//  d_hw          in   1   dmr half-word access
//  d_adr         in   32  dmr byte address
//  d_wdata       in   32  dmr write data
//  d_valid       out  1   dmr completion pulse
//  d_rdata       out  32  dmr read data, valid with d_valid
//  m_req         out  1   bus request pulse (1 cycle)
//  m_we          out  1   bus write
//  m_w / m_hw    out  1   bus size (held from grant to completion)
//  m_adr         out  32  bus address (held)
//  m_wdata       out  32  bus write data (held)
//  m_valid       in   1   bus completion pulse
//  m_rdata       in   32  bus read data
//  bus_err       out  1   1-cycle pulse on timeout completion
//  proto_err     out  1   sticky: req while same requester pending; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pend_i=pend_d=0, rr pointer=DMR, counter 0.
//  - Capture: on x_req, set pend_x and register addr/ctrl/wdata into per-requester slot (cycle N).
//    x_req while pend_x=1 and not completing that cycle: ignored, proto_err<=1. x_req in the same cycle
//    as its own completion is accepted as a new request.
//  - FSM IDLE: if any pend (including one captured this edge is NOT eligible until N+1):
//    pick owner; both pending -> owner = rr pointer; go ISSUE, load m_* from owner slot.
//  - ISSUE (1 cycle): m_req=1; go WAIT, counter<=0. Minimum latency req(N) -> m_req(N+2).
//  - WAIT: m_req=0, m_* held. On m_valid: owner's valid=1 (combinational, same cycle), owner's data=m_rdata,
//    clear pend_owner, rr pointer<=other requester, go IDLE. Else counter++; at counter==TIMEOUT-1:
//    owner's valid=1, data=ERR_DATA, bus_err=1, same exit as m_valid.
//  - m_valid in IDLE/ISSUE: ignored. i_read_valid/d_valid never asserted except as above; never both.
//  - i_read_data/d_rdata: registered hold of last returned word; 0 after reset.
//  - Writes (d_we=1): d_valid on m_valid; d_rdata updated with m_rdata (don't-care value).
//  - Back-to-back: after completion, IDLE->ISSUE next cycle; strict alternation when both keep requesting.
//  - Reset mid-transaction: everything aborted to reset values; late m_valid after reset ignored (IDLE).
// TESTING
//  1 imr req adr=0x100, m_valid 3 cyc after m_req, rdata=0xDEADBEEF -> m_req at N+2, m_adr=0x100,
//    i_read_valid 1 cyc with 0xDEADBEEF, d_valid stays 0.
//  2 i_read_req & d_req same cycle after reset -> dmr granted first, then imr; m_req twice, correct routing.
//  3 Both requesters re-request on each completion for 6 transactions -> grants alternate D,I,D,I,D,I.
//  4 d write adr=0x8000_0004 wdata=0x1234, m_valid never -> after TIMEOUT cycles d_valid=1, bus_err=1,
//    FSM back to IDLE, next imr request served normally.
//  5 Second d_req while dmr pending -> proto_err=1 sticky, only one m_req for dmr, stays 1 until rst_n.
//  6 rst_n low during WAIT, m_valid 1 cyc after release -> no valid output, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter : round-robin sharing of one memory bus between the
//                   instruction-read and load/store requesters, with watchdog.
// Revision 1.0
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int          TIMEOUT  = 256,
  parameter int          TO_W     = 9,
  parameter logic [31:0] ERR_DATA = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read_req,
  input  logic        i_read_w,
  input  logic        i_read_hw,
  input  logic [31:0] i_read_adr,
  output logic        i_read_valid,
  output logic [31:0] i_read_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_w,
  input  logic        d_hw,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic        m_w,
  output logic        m_hw,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdata,
  input  logic        m_valid,
  input  logic [31:0] m_rdata,
  output logic        bus_err,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t      state;
  logic        pend_i, pend_d;
  logic        rr_d;      // 1: dmr wins when both are pending
  logic        owner_d;   // 1: dmr owns the bus
  logic [TO_W-1:0] cnt;

  logic        si_w, si_hw;
  logic [31:0] si_adr;
  logic        sd_we, sd_w, sd_hw;
  logic [31:0] sd_adr, sd_wdata;

  logic [31:0] i_data_q, d_data_q;

  logic        in_wait, cnt_last, done, grant_d;
  logic [31:0] ret_word;

  assign in_wait  = (state == WAIT);
  assign cnt_last = (cnt == TO_W'(TIMEOUT - 1));
  assign done     = in_wait && (m_valid || cnt_last);
  assign bus_err  = in_wait && !m_valid && cnt_last;
  assign ret_word = m_valid ? m_rdata : ERR_DATA;
  assign grant_d  = pend_d && (!pend_i || rr_d);

  // Completion is visible in the same cycle as m_valid; data falls back to the held word.
  assign i_read_valid = done && !owner_d;
  assign d_valid      = done && owner_d;
  assign i_read_data  = i_read_valid ? ret_word : i_data_q;
  assign d_rdata      = d_valid ? ret_word : d_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend_i    <= 1'b0;
      pend_d    <= 1'b0;
      rr_d      <= 1'b1;
      owner_d   <= 1'b0;
      cnt       <= '0;
      proto_err <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_w       <= 1'b0;
      m_hw      <= 1'b0;
      m_adr     <= '0;
      m_wdata   <= '0;
      si_w      <= 1'b0;
      si_hw     <= 1'b0;
      si_adr    <= '0;
      sd_we     <= 1'b0;
      sd_w      <= 1'b0;
      sd_hw     <= 1'b0;
      sd_adr    <= '0;
      sd_wdata  <= '0;
      i_data_q  <= '0;
      d_data_q  <= '0;
    end else begin
      m_req <= 1'b0;
      case (state)
        IDLE: begin
          if (pend_i || pend_d) begin
            owner_d <= grant_d;
            state   <= ISSUE;
            m_req   <= 1'b1;
            if (grant_d) begin
              m_we    <= sd_we;
              m_w     <= sd_w;
              m_hw    <= sd_hw;
              m_adr   <= sd_adr;
              m_wdata <= sd_wdata;
            end else begin
              m_we    <= 1'b0;
              m_w     <= si_w;
              m_hw    <= si_hw;
              m_adr   <= si_adr;
              m_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (done) begin
            state <= IDLE;
            rr_d  <= !owner_d;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (i_read_valid) i_data_q <= ret_word;
      if (d_valid)      d_data_q <= ret_word;

      // A request landing on its own completion cycle starts the next transaction.
      if (i_read_req && (!pend_i || i_read_valid)) begin
        pend_i <= 1'b1;
        si_w   <= i_read_w;
        si_hw  <= i_read_hw;
        si_adr <= i_read_adr;
      end else if (i_read_valid) begin
        pend_i <= 1'b0;
      end
      if (i_read_req && pend_i && !i_read_valid) proto_err <= 1'b1;

      if (d_req && (!pend_d || d_valid)) begin
        pend_d   <= 1'b1;
        sd_we    <= d_we;
        sd_w     <= d_w;
        sd_hw    <= d_hw;
        sd_adr   <= d_adr;
        sd_wdata <= d_wdata;
      end else if (d_valid) begin
        pend_d <= 1'b0;
      end
      if (d_req && pend_d && !d_valid) proto_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter : directed scenarios plus randomized traffic against a
//                      transaction-level model of the arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_read_req, i_read_w, i_read_hw, i_read_valid;
  logic [31:0] i_read_adr, i_read_data;
  logic        d_req, d_we, d_w, d_hw, d_valid;
  logic [31:0] d_adr, d_wdata, d_rdata;
  logic        m_req, m_we, m_w, m_hw, m_valid, bus_err, proto_err;
  logic [31:0] m_adr, m_wdata, m_rdata;

  mem_bus_arbiter #(.TIMEOUT(TO), .TO_W(5), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw),
    .i_read_adr(i_read_adr), .i_read_valid(i_read_valid), .i_read_data(i_read_data),
    .d_req(d_req), .d_we(d_we), .d_w(d_w), .d_hw(d_hw), .d_adr(d_adr),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_w(m_w), .m_hw(m_hw), .m_adr(m_adr),
    .m_wdata(m_wdata), .m_valid(m_valid), .m_rdata(m_rdata),
    .bus_err(bus_err), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: who is waiting, what they asked for, who holds the bus and for how long.
  logic        md_pend_i, md_pend_d, md_rr_d, md_busy, md_own_d, md_proto;
  int          md_g;  // cycles since the bus request of the current transaction
  logic        md_si_w, md_si_hw, md_sd_we, md_sd_w, md_sd_hw;
  logic [31:0] md_si_adr, md_sd_adr, md_sd_wdata;
  logic        md_m_we, md_m_w, md_m_hw;
  logic [31:0] md_m_adr, md_m_wdata, md_last_i, md_last_d;

  int          rsp_lat;     // bus response delay; 0 = bus hangs
  int          force_lat = -1;
  logic        force_mv = 1'b0, force_rd_en = 1'b0, spur_en = 1'b0;
  logic [31:0] force_rd = '0;
  logic        rereq = 1'b0, rnd = 1'b0;

  logic        ob_mreq, ob_mwe, ob_iv, ob_dv, ob_berr, ob_proto, ob_zero;
  logic [31:0] ob_madr, ob_mwdata, ob_idata, ob_ddata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    md_pend_i = 0; md_pend_d = 0; md_rr_d = 1; md_busy = 0; md_own_d = 0; md_proto = 0;
    md_g = 0; md_si_w = 0; md_si_hw = 0; md_si_adr = '0;
    md_sd_we = 0; md_sd_w = 0; md_sd_hw = 0; md_sd_adr = '0; md_sd_wdata = '0;
    md_m_we = 0; md_m_w = 0; md_m_hw = 0; md_m_adr = '0; md_m_wdata = '0;
    md_last_i = '0; md_last_d = '0; rsp_lat = 0;
  endtask

  task automatic model_step(input logic cmp, input logic [31:0] ret);
    logic pi, pd, own, gd;
    pi = md_pend_i; pd = md_pend_d; own = md_own_d;
    gd = pd && (!pi || md_rr_d);
    if (cmp) begin
      if (own) begin md_pend_d = 0; md_last_d = ret; end
      else     begin md_pend_i = 0; md_last_i = ret; end
      md_rr_d = !own;
      md_busy = 0;
    end else if (md_busy) begin
      md_g++;
    end else if (pi || pd) begin
      md_busy = 1; md_g = 0; md_own_d = gd;
      if (gd) begin
        md_m_we = md_sd_we; md_m_w = md_sd_w; md_m_hw = md_sd_hw;
        md_m_adr = md_sd_adr; md_m_wdata = md_sd_wdata;
      end else begin
        md_m_we = 0; md_m_w = md_si_w; md_m_hw = md_si_hw;
        md_m_adr = md_si_adr; md_m_wdata = '0;
      end
      if (force_lat >= 0) rsp_lat = force_lat;
      else rsp_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
    end
    if (i_read_req) begin
      if (pi && !(cmp && !own)) md_proto = 1;
      else begin md_pend_i = 1; md_si_w = i_read_w; md_si_hw = i_read_hw; md_si_adr = i_read_adr; end
    end
    if (d_req) begin
      if (pd && !(cmp && own)) md_proto = 1;
      else begin
        md_pend_d = 1; md_sd_we = d_we; md_sd_w = d_w; md_sd_hw = d_hw;
        md_sd_adr = d_adr; md_sd_wdata = d_wdata;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic cmp, to;
    logic [31:0] ret;
    @(negedge clk);
    to  = md_busy && md_g >= 1 && !m_valid && md_g == TO;
    cmp = md_busy && md_g >= 1 && (m_valid || md_g == TO);
    ret = to ? ERR : m_rdata;
    chk("i_read_valid", 32'(i_read_valid), 32'(cmp && !md_own_d));
    chk("d_valid", 32'(d_valid), 32'(cmp && md_own_d));
    chk("i_read_data", i_read_data, (cmp && !md_own_d) ? ret : md_last_i);
    chk("d_rdata", d_rdata, (cmp && md_own_d) ? ret : md_last_d);
    chk("bus_err", 32'(bus_err), 32'(to));
    chk("m_req", 32'(m_req), 32'(md_busy && md_g == 0));
    chk("m_we", 32'(m_we), 32'(md_m_we));
    chk("m_w", 32'(m_w), 32'(md_m_w));
    chk("m_hw", 32'(m_hw), 32'(md_m_hw));
    chk("m_adr", m_adr, md_m_adr);
    chk("m_wdata", m_wdata, md_m_wdata);
    chk("proto_err", 32'(proto_err), 32'(md_proto));
    ob_mreq = m_req; ob_mwe = m_we; ob_madr = m_adr; ob_mwdata = m_wdata;
    ob_iv = i_read_valid; ob_idata = i_read_data; ob_dv = d_valid; ob_ddata = d_rdata;
    ob_berr = bus_err; ob_proto = proto_err;
    ob_zero = !(i_read_valid | d_valid | m_req | m_we | m_w | m_hw | bus_err | proto_err)
              && (i_read_data | d_rdata | m_adr | m_wdata) == 32'h0;
    @(posedge clk);
    if (rst_n) model_step(cmp, ret);
    #1;
  endtask

  task automatic drive_bus();
    m_valid = 1'b0;
    if (force_mv) m_valid = 1'b1;
    else if (md_busy && md_g >= 1) m_valid = (rsp_lat != 0 && md_g == rsp_lat);
    else if (spur_en) m_valid = ($urandom_range(0, 7) == 0);
    m_rdata = force_rd_en ? force_rd : $urandom;
  endtask

  task automatic step();
    logic wc;
    drive_bus();
    wc = md_busy && md_g >= 1 && (m_valid || md_g == TO);
    if (rereq && wc) begin
      if (md_own_d) d_req = 1'b1; else i_read_req = 1'b1;
    end
    if (rnd) begin
      if ((!md_pend_i || (wc && !md_own_d)) && $urandom_range(0, 2) == 0) begin
        i_read_req = 1; i_read_adr = $urandom; i_read_w = $urandom; i_read_hw = $urandom;
      end
      if ((!md_pend_d || (wc && md_own_d)) && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom; d_w = $urandom; d_hw = $urandom;
        d_adr = $urandom; d_wdata = $urandom;
      end
    end
    cycle();
    i_read_req = 1'b0;
    d_req      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    i_read_req = 0; d_req = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, cnt;
    logic seen, found;
    string seq;
    rst_n = 1'b0; model_reset();
    i_read_req = 0; i_read_w = 0; i_read_hw = 0; i_read_adr = '0;
    d_req = 0; d_we = 0; d_w = 0; d_hw = 0; d_adr = '0; d_wdata = '0;
    m_valid = 0; m_rdata = '0;
    #1;
    do_reset();
    chk("reset_all_zero", 32'(ob_zero), 32'd1);

    // 1: single instruction read, response 3 cycles after m_req
    force_lat = 3; force_rd_en = 1; force_rd = 32'hDEAD_BEEF;
    i_read_req = 1; i_read_adr = 32'h100; i_read_w = 1; i_read_hw = 0;
    step();
    step();
    chk("t1_no_early_mreq", 32'(ob_mreq), 32'd0);
    step();
    chk("t1_mreq_n2", 32'(ob_mreq), 32'd1);
    chk("t1_madr", ob_madr, 32'h100);
    step(); step(); step();
    chk("t1_ivalid", 32'(ob_iv), 32'd1);
    chk("t1_idata", ob_idata, 32'hDEAD_BEEF);
    chk("t1_dvalid", 32'(ob_dv), 32'd0);
    force_rd_en = 0;

    // 2: simultaneous requests after reset, dmr first
    do_reset();
    i_read_req = 1; i_read_adr = 32'h300; d_req = 1; d_we = 0; d_adr = 32'h200;
    step(); step(); step();
    chk("t2_first_mreq", 32'(ob_mreq), 32'd1);
    chk("t2_first_adr", ob_madr, 32'h200);
    step(); step(); step();
    chk("t2_dvalid", 32'(ob_dv), 32'd1);
    chk("t2_not_ivalid", 32'(ob_iv), 32'd0);
    step(); step();
    chk("t2_second_mreq", 32'(ob_mreq), 32'd1);
    chk("t2_second_adr", ob_madr, 32'h300);
    step(); step(); step();
    chk("t2_ivalid", 32'(ob_iv), 32'd1);

    // 3: both re-request on every completion -> strict alternation
    do_reset();
    force_lat = 2; seq = "";
    i_read_req = 1; d_req = 1; rereq = 1;
    for (int k = 0; k < 200 && seq.len() < 6; k++) begin
      step();
      if (ob_mreq) seq = {seq, (ob_madr == 32'h200) ? "D" : "I"};
    end
    rereq = 0;
    checks++;
    if (seq != "DIDIDI") begin
      errors++;
      $display("FAIL t3_alternation: got %s expected DIDIDI", seq);
    end
    repeat (20) step();

    // 4: write to a hung bus -> watchdog completion
    do_reset();
    force_lat = 0;
    d_req = 1; d_we = 1; d_w = 1; d_hw = 0; d_adr = 32'h8000_0004; d_wdata = 32'h1234;
    step();
    n = 0; seen = 0; found = 0;
    for (int k = 0; k < TO + 20 && !found; k++) begin
      step();
      if (ob_mreq) begin
        seen = 1; n = 0;
        chk("t4_madr", ob_madr, 32'h8000_0004);
        chk("t4_mwdata", ob_mwdata, 32'h1234);
        chk("t4_mwe", 32'(ob_mwe), 32'd1);
      end else if (seen) n++;
      if (ob_dv) found = 1;
    end
    chk("t4_found", 32'(found), 32'd1);
    chk("t4_wait_len", 32'(n), 32'(TO));
    chk("t4_bus_err", 32'(ob_berr), 32'd1);
    chk("t4_err_data", ob_ddata, ERR);
    step();
    force_lat = 2; force_rd_en = 1; force_rd = 32'hCAFE_F00D;
    i_read_req = 1; i_read_adr = 32'h40;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (ob_iv) found = 1;
    end
    chk("t4_next_read", 32'(found), 32'd1);
    chk("t4_next_data", ob_idata, 32'hCAFE_F00D);
    force_rd_en = 0;

    // 5: duplicate dmr request while pending
    do_reset();
    force_lat = 4;
    d_req = 1; d_we = 0; d_adr = 32'h400;
    step();
    d_req = 1;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (ob_mreq) cnt++;
    end
    chk("t5_one_mreq", 32'(cnt), 32'd1);
    chk("t5_proto_sticky", 32'(ob_proto), 32'd1);

    // 6: reset during WAIT, late m_valid ignored
    force_lat = 0;
    d_req = 1; d_adr = 32'h500;
    step(); step(); step(); step(); step();
    rst_n = 0; model_reset();
    step();
    chk("t6_zero_in_reset", 32'(ob_zero), 32'd1);
    rst_n = 1;
    force_mv = 1;
    step();
    force_mv = 0;
    chk("t6_no_valid", 32'(ob_iv | ob_dv), 32'd0);
    chk("t6_zero_after", 32'(ob_zero), 32'd1);
    step();

    // Randomized traffic, random latencies, occasional hangs and stray m_valid
    do_reset();
    force_lat = -1; spur_en = 1; rnd = 1;
    repeat (4000) step();
    rnd = 0; spur_en = 0;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
